// File: rtl/model_vector_summation_feeder_if.sv
// Handshake/bus bundle for model_vector_summation_feeder.
// Groups the producer side (START/DATA_IN...), the summation-unit side
// (START_OUT/NEXT_*/DATA_OUT...) and the status pulses (READY/ERROR).
// The optional REPLAY input exists only when
// MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN is defined.
interface model_vector_summation_feeder_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    START;
  logic                    READY;
  logic                    ERROR;
  logic                    DATA_IN_ENABLE;
  logic [CONTROL_SIZE-1:0] SIZE_IN;
  logic [CONTROL_SIZE-1:0] LENGTH_IN;
  logic [DATA_SIZE-1:0]    DATA_IN;
  logic                    START_OUT;
  logic                    READY_IN;
  logic                    NEXT_VECTOR_IN;
  logic                    NEXT_SCALAR_IN;
  logic                    DATA_OUT_VECTOR_ENABLE;
  logic                    DATA_OUT_SCALAR_ENABLE;
  logic [CONTROL_SIZE-1:0] SIZE_OUT;
  logic [CONTROL_SIZE-1:0] LENGTH_OUT;
  logic [DATA_SIZE-1:0]    DATA_OUT;
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
  logic                    REPLAY;

  // Producer/summation-unit side: drives the feeder inputs.
  modport master (
    output START, DATA_IN_ENABLE, SIZE_IN, LENGTH_IN, DATA_IN,
           READY_IN, NEXT_VECTOR_IN, NEXT_SCALAR_IN, REPLAY,
    input  READY, ERROR, START_OUT, DATA_OUT_VECTOR_ENABLE,
           DATA_OUT_SCALAR_ENABLE, SIZE_OUT, LENGTH_OUT, DATA_OUT
  );

  // Feeder side.
  modport slave (
    input  START, DATA_IN_ENABLE, SIZE_IN, LENGTH_IN, DATA_IN,
           READY_IN, NEXT_VECTOR_IN, NEXT_SCALAR_IN, REPLAY,
    output READY, ERROR, START_OUT, DATA_OUT_VECTOR_ENABLE,
           DATA_OUT_SCALAR_ENABLE, SIZE_OUT, LENGTH_OUT, DATA_OUT
  );
`else
  // Producer/summation-unit side: drives the feeder inputs.
  modport master (
    output START, DATA_IN_ENABLE, SIZE_IN, LENGTH_IN, DATA_IN,
           READY_IN, NEXT_VECTOR_IN, NEXT_SCALAR_IN,
    input  READY, ERROR, START_OUT, DATA_OUT_VECTOR_ENABLE,
           DATA_OUT_SCALAR_ENABLE, SIZE_OUT, LENGTH_OUT, DATA_OUT
  );

  // Feeder side.
  modport slave (
    input  START, DATA_IN_ENABLE, SIZE_IN, LENGTH_IN, DATA_IN,
           READY_IN, NEXT_VECTOR_IN, NEXT_SCALAR_IN,
    output READY, ERROR, START_OUT, DATA_OUT_VECTOR_ENABLE,
           DATA_OUT_SCALAR_ENABLE, SIZE_OUT, LENGTH_OUT, DATA_OUT
  );
`endif
endinterface

// File: rtl/model_vector_summation_feeder.sv
// model_vector_summation_feeder
// Captures one SIZE x LENGTH operand set from a bursty producer into a local
// buffer, then replays it to the vector summation unit paced by that unit's
// output enables. Optional replay of the retained set is enabled with
// `define MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN (adds bus.REPLAY).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for START (or REPLAY); size check happens here
// S_LOAD  | writing producer words into the buffer until total are stored
// S_ISSUE | START_OUT + first word (vector enable) visible for one cycle
// S_WAIT  | serving NEXT_VECTOR_IN / NEXT_SCALAR_IN until READY_IN
// S_DONE  | READY pulse visible for one cycle
//
// All outputs are registered and loaded together with the state they belong
// to, so a NEXT_* pulse sampled at an edge shows its word right after that
// edge (one cycle of latency), and READY is visible during S_DONE.
module model_vector_summation_feeder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int DEPTH        = 64
) (
  input logic CLK,
  input logic RST,
  model_vector_summation_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  // Read pointer must be able to hold DEPTH itself (end-of-set marker).
  localparam int PW = AW + 1;
  localparam logic [CONTROL_SIZE-1:0] DEPTH_C = CONTROL_SIZE'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0]    mem_q [DEPTH];
  logic                    mem_we;

  logic [AW-1:0]           wptr_q, wptr_d;
  logic [PW-1:0]           rptr_q, rptr_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] j_q, j_d;
  logic [CONTROL_SIZE-1:0] total_q, total_d;
  logic [CONTROL_SIZE-1:0] size_q, size_d;
  logic [CONTROL_SIZE-1:0] length_q, length_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic                    start_out_q, start_out_d;
  logic                    vec_en_q, vec_en_d;
  logic                    sca_en_q, sca_en_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
  logic                    loaded_q, loaded_d;
`endif

  logic [CONTROL_SIZE-1:0] product;
  logic                    last_write;
  logic                    rd_end;

  // Truncated operand count; compared against DEPTH before any load starts.
  assign product    = bus.SIZE_IN * bus.LENGTH_IN;
  assign last_write = (CONTROL_SIZE'(wptr_q) == total_q - CONTROL_SIZE'(1));
  assign rd_end     = (CONTROL_SIZE'(rptr_q) == total_q);

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    i_d         = i_q;
    j_d         = j_q;
    total_d     = total_q;
    size_d      = size_q;
    length_d    = length_q;
    data_d      = data_q;
    start_out_d = 1'b0;
    vec_en_d    = 1'b0;
    sca_en_d    = 1'b0;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    mem_we      = 1'b0;
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
    loaded_d    = loaded_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          size_d   = bus.SIZE_IN;
          length_d = bus.LENGTH_IN;
          total_d  = product;
          wptr_d   = '0;
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
          // The latched geometry no longer describes the retained buffer.
          loaded_d = 1'b0;
`endif
          if (product > DEPTH_C) begin
            error_d = 1'b1;
          end else if (product == '0) begin
            ready_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
        else if (bus.REPLAY && loaded_q) begin
          state_d     = S_ISSUE;
          start_out_d = 1'b1;
          vec_en_d    = 1'b1;
          data_d      = mem_q[0];
          rptr_d      = PW'(1);
          i_d         = '0;
          j_d         = '0;
        end
`endif
      end

      S_LOAD: begin
        if (bus.DATA_IN_ENABLE) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (last_write) begin
            state_d     = S_ISSUE;
            start_out_d = 1'b1;
            vec_en_d    = 1'b1;
            rptr_d      = PW'(1);
            i_d         = '0;
            j_d         = '0;
            // A one-word set writes word 0 on this same edge: bypass it.
            data_d      = (wptr_q == '0) ? bus.DATA_IN : mem_q[0];
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
            loaded_d    = 1'b1;
`endif
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.READY_IN) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else if (!rd_end) begin
          if (bus.NEXT_VECTOR_IN) begin
            vec_en_d = 1'b1;
            data_d   = mem_q[rptr_q[AW-1:0]];
            i_d      = i_q + CONTROL_SIZE'(1);
            j_d      = '0;
            rptr_d   = rptr_q + PW'(1);
          end else if (bus.NEXT_SCALAR_IN) begin
            sca_en_d = 1'b1;
            data_d   = mem_q[rptr_q[AW-1:0]];
            j_d      = j_q + CONTROL_SIZE'(1);
            rptr_d   = rptr_q + PW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointers, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      total_q     <= '0;
      size_q      <= '0;
      length_q    <= '0;
      data_q      <= '0;
      start_out_q <= 1'b0;
      vec_en_q    <= 1'b0;
      sca_en_q    <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      i_q         <= i_d;
      j_q         <= j_d;
      total_q     <= total_d;
      size_q      <= size_d;
      length_q    <= length_d;
      data_q      <= data_d;
      start_out_q <= start_out_d;
      vec_en_q    <= vec_en_d;
      sca_en_q    <= sca_en_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
  // Marks that the buffer holds a complete set matching SIZE_OUT/LENGTH_OUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
    end
  end
`endif

  // Operand buffer; contents are irrelevant after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[wptr_q] <= bus.DATA_IN;
    end
  end

  assign bus.START_OUT              = start_out_q;
  assign bus.DATA_OUT_VECTOR_ENABLE = vec_en_q;
  assign bus.DATA_OUT_SCALAR_ENABLE = sca_en_q;
  assign bus.READY                  = ready_q;
  assign bus.ERROR                  = error_q;
  assign bus.SIZE_OUT               = size_q;
  assign bus.LENGTH_OUT             = length_q;
  assign bus.DATA_OUT               = data_q;

endmodule

// File: tb/tb_model_vector_summation_feeder.sv
// Bench for model_vector_summation_feeder: random operand sets are loaded,
// and the expected replay is derived from the stored word list in summation
// order (word k is a vector head when k is a multiple of LENGTH).
module tb_model_vector_summation_feeder;
  localparam int DW    = 64;
  localparam int CW    = 64;
  localparam int DEPTH = 64;

  localparam logic [4:0] F_NONE  = 5'b00000;
  localparam logic [4:0] F_START = 5'b10000;
  localparam logic [4:0] F_VEC   = 5'b01000;
  localparam logic [4:0] F_SCA   = 5'b00100;
  localparam logic [4:0] F_READY = 5'b00010;
  localparam logic [4:0] F_ERR   = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] words[$];
  int            cur_len;
  int            cur_total;
  int            next_idx;

  model_vector_summation_feeder_if #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) bus ();

  model_vector_summation_feeder #(
    .DATA_SIZE(DW), .CONTROL_SIZE(CW), .DEPTH(DEPTH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] flags();
    return {bus.START_OUT, bus.DATA_OUT_VECTOR_ENABLE,
            bus.DATA_OUT_SCALAR_ENABLE, bus.READY, bus.ERROR};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.START          = 1'b0;
    bus.DATA_IN_ENABLE = 1'b0;
    bus.SIZE_IN        = '0;
    bus.LENGTH_IN      = '0;
    bus.DATA_IN        = '0;
    bus.READY_IN       = 1'b0;
    bus.NEXT_VECTOR_IN = 1'b0;
    bus.NEXT_SCALAR_IN = 1'b0;
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
    bus.REPLAY         = 1'b0;
`endif
  endtask

  // START a set, feed its words (optional gaps / stray STARTs), check ISSUE.
  task automatic load_set(input int size, input int length, input bit seq,
                          input int gap_max, input bit start_noise);
    int total;
    int gaps;
    total = size * length;
    words.delete();
    for (int k = 0; k < total; k++)
      words.push_back(seq ? DW'(k + 1) : {$urandom, $urandom});
    cur_len   = length;
    cur_total = total;
    next_idx  = 1;
    bus.SIZE_IN   = CW'(size);
    bus.LENGTH_IN = CW'(length);
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    checks++;
    if (flags() !== F_NONE) begin
      failures++;
      $display("FAIL start_accept flags=%b exp=%b", flags(), F_NONE);
    end
    for (int k = 0; k < total; k++) begin
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        bus.DATA_IN_ENABLE = 1'b0;
        bus.DATA_IN        = {$urandom, $urandom};
        if (start_noise) begin
          bus.START   = 1'($urandom_range(0, 1));
          bus.SIZE_IN = CW'($urandom_range(0, 3));
        end
        tick();
        checks++;
        if (flags() !== F_NONE) begin
          failures++;
          $display("FAIL load_gap word=%0d flags=%b exp=%b", k, flags(), F_NONE);
        end
      end
      bus.START          = 1'b0;
      bus.DATA_IN_ENABLE = 1'b1;
      bus.DATA_IN        = words[k];
      tick();
      if (k < total - 1) begin
        checks++;
        if (flags() !== F_NONE) begin
          failures++;
          $display("FAIL load_word word=%0d flags=%b exp=%b", k, flags(), F_NONE);
        end
      end
    end
    bus.DATA_IN_ENABLE = 1'b0;
    checks++;
    if (flags() !== (F_START | F_VEC) || bus.DATA_OUT !== words[0] ||
        bus.SIZE_OUT !== CW'(size) || bus.LENGTH_OUT !== CW'(length)) begin
      failures++;
      $display("FAIL issue flags=%b data=%0h size=%0d len=%0d exp flags=%b data=%0h size=%0d len=%0d",
               flags(), bus.DATA_OUT, bus.SIZE_OUT, bus.LENGTH_OUT,
               F_START | F_VEC, words[0], size, length);
    end
    tick();
    checks++;
    if (flags() !== F_NONE || bus.DATA_OUT !== words[0]) begin
      failures++;
      $display("FAIL issue_pulse flags=%b data=%0h exp flags=%b data=%0h",
               flags(), bus.DATA_OUT, F_NONE, words[0]);
    end
  endtask

  // Request n more words in summation order; both_pct: chance of also
  // raising NEXT_SCALAR_IN alongside a vector request.
  task automatic consume(input int n, input int both_pct, input int gap_max);
    bit vec;
    int gaps;
    for (int c = 0; c < n; c++) begin
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        tick();
        checks++;
        if (flags() !== F_NONE || bus.DATA_OUT !== words[next_idx-1]) begin
          failures++;
          $display("FAIL hold flags=%b data=%0h exp flags=%b data=%0h",
                   flags(), bus.DATA_OUT, F_NONE, words[next_idx-1]);
        end
      end
      vec = (next_idx % cur_len) == 0;
      bus.NEXT_VECTOR_IN = vec;
      bus.NEXT_SCALAR_IN = vec ? ($urandom_range(0, 99) < both_pct) : 1'b1;
      tick();
      bus.NEXT_VECTOR_IN = 1'b0;
      bus.NEXT_SCALAR_IN = 1'b0;
      checks++;
      if (flags() !== (vec ? F_VEC : F_SCA) || bus.DATA_OUT !== words[next_idx]) begin
        failures++;
        $display("FAIL replay k=%0d flags=%b data=%0h exp flags=%b data=%0h", next_idx,
                 flags(), bus.DATA_OUT, vec ? F_VEC : F_SCA, words[next_idx]);
      end
      next_idx++;
    end
  endtask

  // Next pulse after the whole set has been read must be ignored.
  task automatic overrun();
    bus.NEXT_SCALAR_IN = 1'b1;
    tick();
    bus.NEXT_SCALAR_IN = 1'b0;
    checks++;
    if (flags() !== F_NONE || bus.DATA_OUT !== words[cur_total-1]) begin
      failures++;
      $display("FAIL overrun flags=%b data=%0h exp flags=%b data=%0h",
               flags(), bus.DATA_OUT, F_NONE, words[cur_total-1]);
    end
  endtask

  task automatic finish_set(input bit with_scalar);
    bus.READY_IN       = 1'b1;
    bus.NEXT_SCALAR_IN = with_scalar;
    tick();
    bus.READY_IN       = 1'b0;
    bus.NEXT_SCALAR_IN = 1'b0;
    checks++;
    if (flags() !== F_READY || bus.DATA_OUT !== words[next_idx-1]) begin
      failures++;
      $display("FAIL ready flags=%b data=%0h exp flags=%b data=%0h",
               flags(), bus.DATA_OUT, F_READY, words[next_idx-1]);
    end
    tick();
    checks++;
    if (flags() !== F_NONE) begin
      failures++;
      $display("FAIL ready_once flags=%b exp=%b", flags(), F_NONE);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({flags(), bus.SIZE_OUT, bus.LENGTH_OUT, bus.DATA_OUT} !== '0) begin
      failures++;
      $display("FAIL reset flags=%b size=%0h len=%0h data=%0h exp all 0",
               flags(), bus.SIZE_OUT, bus.LENGTH_OUT, bus.DATA_OUT);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_set(2, 3, 1'b1, 0, 1'b0);
    consume(5, 100, 0);
    overrun();
    finish_set(1'b0);
  endtask

  task automatic test_overflow();
    int s;
    int l;
    bus.SIZE_IN   = CW'(9);
    bus.LENGTH_IN = CW'(8);
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    checks++;
    if (flags() !== F_ERR) begin
      failures++;
      $display("FAIL overflow_err flags=%b exp=%b", flags(), F_ERR);
    end
    bus.DATA_IN_ENABLE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (flags() !== F_NONE) begin
        failures++;
        $display("FAIL overflow_idle flags=%b exp=%b", flags(), F_NONE);
      end
    end
    bus.DATA_IN_ENABLE = 1'b0;
    for (int r = 0; r < 4; r++) begin
      s = $urandom_range(1, 20);
      l = DEPTH / s + 1 + $urandom_range(0, 3);
      bus.SIZE_IN   = CW'(s);
      bus.LENGTH_IN = CW'(l);
      bus.START     = 1'b1;
      tick();
      bus.START = 1'b0;
      checks++;
      if (flags() !== F_ERR) begin
        failures++;
        $display("FAIL overflow_rand size=%0d len=%0d flags=%b exp=%b", s, l, flags(), F_ERR);
      end
      tick();
    end
    load_set(8, 8, 1'b0, 1, 1'b0);
    consume(63, 50, 1);
    overrun();
    finish_set(1'b0);
  endtask

  task automatic test_zero();
    for (int r = 0; r < 2; r++) begin
      bus.SIZE_IN   = (r == 0) ? CW'(0) : CW'(7);
      bus.LENGTH_IN = (r == 0) ? CW'(5) : CW'(0);
      bus.START     = 1'b1;
      tick();
      bus.START = 1'b0;
      checks++;
      if (flags() !== F_READY) begin
        failures++;
        $display("FAIL zero_ready case=%0d flags=%b exp=%b", r, flags(), F_READY);
      end
      bus.DATA_IN_ENABLE = 1'b1;
      for (int c = 0; c < 3; c++) begin
        bus.DATA_IN = {$urandom, $urandom};
        tick();
        checks++;
        if (flags() !== F_NONE) begin
          failures++;
          $display("FAIL zero_idle case=%0d flags=%b exp=%b", r, flags(), F_NONE);
        end
      end
      bus.DATA_IN_ENABLE = 1'b0;
    end
  endtask

  task automatic test_gapped();
    load_set(1, 4, 1'b0, 3, 1'b1);
    consume(3, 0, 2);
    overrun();
    finish_set(1'b0);
  endtask

  task automatic test_simultaneous();
    load_set(3, 2, 1'b0, 0, 1'b0);
    consume(2, 100, 0);
    finish_set(1'b1);
  endtask

  task automatic test_random();
    int s;
    int l;
    load_set(1, 1, 1'b0, 2, 1'b0);
    overrun();
    finish_set(1'b1);
    for (int r = 0; r < 5; r++) begin
      s = $urandom_range(1, 8);
      l = $urandom_range(1, 8);
      load_set(s, l, 1'b0, 2, 1'b1);
      consume(s * l - 1, 50, 2);
      overrun();
      finish_set(1'($urandom_range(0, 1)));
    end
  endtask

`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
  task automatic test_replay();
    load_set(2, 3, 1'b1, 0, 1'b0);
    consume(5, 0, 0);
    finish_set(1'b0);
    next_idx = 1;
    bus.REPLAY = 1'b1;
    tick();
    bus.REPLAY = 1'b0;
    checks++;
    if (flags() !== (F_START | F_VEC) || bus.DATA_OUT !== words[0]) begin
      failures++;
      $display("FAIL replay_issue flags=%b data=%0h exp flags=%b data=%0h",
               flags(), bus.DATA_OUT, F_START | F_VEC, words[0]);
    end
    tick();
    consume(5, 0, 1);
    finish_set(1'b0);
  endtask
`endif

  task automatic test_reset_mid();
    load_set(2, 3, 1'b1, 0, 1'b0);
    consume(2, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({flags(), bus.SIZE_OUT, bus.LENGTH_OUT, bus.DATA_OUT} !== '0) begin
      failures++;
      $display("FAIL reset_mid flags=%b size=%0h len=%0h data=%0h exp all 0",
               flags(), bus.SIZE_OUT, bus.LENGTH_OUT, bus.DATA_OUT);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (flags() !== F_NONE) begin
        failures++;
        $display("FAIL reset_no_ready flags=%b exp=%b", flags(), F_NONE);
      end
    end
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
    bus.REPLAY = 1'b1;
    tick();
    bus.REPLAY = 1'b0;
    checks++;
    if (flags() !== F_NONE) begin
      failures++;
      $display("FAIL replay_after_reset flags=%b exp=%b", flags(), F_NONE);
    end
`endif
    load_set(2, 3, 1'b0, 1, 1'b0);
    consume(5, 30, 1);
    overrun();
    finish_set(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_gapped();
    test_simultaneous();
    test_random();
`ifdef MODEL_VECTOR_SUMMATION_FEEDER_REPLAY_EN
    test_replay();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
